timer_control: RTL and testbench

Run/pause/stop controller for the minutes:seconds down-timer. It sits directly upstream of the digit counter chain (units-of-seconds mod-10, tens-of-seconds mod-6, minutes). It turns user commands into the chain's `enable`, `loadn` and clear strobes, generates the once-per-second count tick, and watches the chain's all-digits-zero flag to stop and raise `done`.

---
 rtl/timer_control_if.sv | 19 +
 rtl/timer_control.sv | 88 ++++++++
 tb/tb_timer_control.sv | 132 +++++++++++++
 3 files changed

// File: rtl/timer_control_if.sv
// timer_control_if: command, status and digit-chain strobe bundle for the down-timer controller
interface timer_control_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic       timer_zero;
  logic       enable;
  logic       loadn;
  logic       cnt_clrn;
  logic       running;
  logic       paused;
  logic       done;
  logic [1:0] state;
  modport master (output start, stop, clear, load, timer_zero,
                  input enable, loadn, cnt_clrn, running, paused, done, state);
  modport slave (input start, stop, clear, load, timer_zero,
                 output enable, loadn, cnt_clrn, running, paused, done, state);
endinterface

// File: rtl/timer_control.sv
// timer_control: run/pause/stop controller driving the mm:ss digit chain
// with a once-per-TICK_DIV count tick, load/clear strobes and expiry detection.
module timer_control #(
  parameter int TICK_DIV = 50_000_000
) (
  input logic             clock,
  input logic             clrn,
  timer_control_if.slave  bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t          state_q, state_d;
  logic [3:0]      samp_q, prev_q;
  logic [PW-1:0]   pre_q, pre_d;
  logic            enable_q, enable_d, loadn_q, loadn_d, clr_q, clr_d;
  logic [3:0]      evt;
  logic            ev_clr, ev_stp, ev_sta, ev_ld, wrap;
  // command bits ordered by priority: {clear, stop, start, load}
  assign evt    = samp_q & ~prev_q;
  assign ev_clr = evt[3];
  assign ev_stp = evt[2] & ~evt[3];
  assign ev_sta = evt[1] & ~|evt[3:2];
  assign ev_ld  = evt[0] & ~|evt[3:1];
  assign wrap   = pre_q == PW'(TICK_DIV - 1);
  always_comb begin
    state_d = state_q;
    loadn_d = 1'b1;
    clr_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (ev_sta && !bus.timer_zero) state_d = RUN;
        loadn_d = ~ev_ld;
        clr_d   = ~ev_clr;
      end
      RUN: begin
        if (ev_clr) begin
          state_d = IDLE;
          clr_d   = 1'b0;
        end else if (bus.timer_zero) state_d = DONE;
        else if (ev_stp) state_d = PAUSE;
      end
      PAUSE: begin
        if (ev_clr || ev_stp) begin
          state_d = IDLE;
          clr_d   = 1'b0;
        end else if (ev_sta) state_d = RUN;
      end
      default: begin
        state_d = (ev_clr || ev_ld) ? IDLE : DONE;
        clr_d   = ~ev_clr;
        loadn_d = ~ev_ld;
      end
    endcase
  end
  // the prescaler keeps its phase across PAUSE and only restarts from IDLE/DONE
  always_comb begin
    pre_d    = (state_d == IDLE || state_d == DONE) ? '0 :
               (state_q != RUN) ? pre_q :
               wrap ? '0 : pre_q + PW'(1);
    enable_d = (state_q == RUN) && (state_d == RUN) && wrap;
  end
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      prev_q   <= '0;
      pre_q    <= '0;
      enable_q <= 1'b0;
      loadn_q  <= 1'b1;
      clr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      samp_q   <= {bus.clear, bus.stop, bus.start, bus.load};
      prev_q   <= samp_q;
      pre_q    <= pre_d;
      enable_q <= enable_d;
      loadn_q  <= loadn_d;
      clr_q    <= clr_d;
    end
  end
  assign bus.enable   = enable_q;
  assign bus.loadn    = loadn_q;
  assign bus.cnt_clrn = clr_q;
  assign bus.running  = state_q == RUN;
  assign bus.paused   = state_q == PAUSE;
  assign bus.done     = state_q == DONE;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_timer_control.sv
// tb_timer_control: directed checks of timer_control with TICK_DIV=4
module tb_timer_control;
  logic clock = 1'b0;
  logic clrn  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  timer_control_if bus();
  timer_control #(.TICK_DIV(4)) dut (.clock(clock), .clrn(clrn), .bus(bus));
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] outs();
    return {1'b0, bus.state, bus.enable, bus.loadn, bus.cnt_clrn, bus.running, bus.done};
  endfunction
  initial begin
    int changes;
    logic [1:0] last;
    bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0; bus.timer_zero = 0;
    #1 clrn = 1'b0;
    #11;
    chk("reset_outs", outs(), 8'b0_00_0_1_1_0_0);
    chk("reset_paused", 8'(bus.paused), 8'h0);
    step();
    clrn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_quiet", outs(), 8'b0_00_0_1_1_0_0);
    end
    bus.load = 1;
    step(); step();
    chk("load_strobe", outs(), 8'b0_00_0_0_1_0_0);
    bus.load = 0;
    step();
    chk("load_once", outs(), 8'b0_00_0_1_1_0_0);
    bus.start = 1;
    step(); step();
    chk("run_entry", outs(), 8'b0_01_0_1_1_1_0);
    bus.start = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("tick_spacing", 8'(bus.enable), 8'((i % 4) == 0));
    end
    bus.stop = 1;
    step();
    chk("pre_stop_tick", 8'(bus.enable), 8'h0);
    step();
    chk("pause_entry", {6'b0, bus.paused, bus.enable}, 8'b10);
    chk("pause_state", 8'(bus.state), 8'h2);
    bus.stop = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_hold", {5'b0, bus.state, bus.enable}, 8'b100);
    end
    bus.start = 1;
    step(); step();
    chk("resume", outs(), 8'b0_01_0_1_1_1_0);
    bus.start = 0;
    step();
    chk("resume_p3", 8'(bus.enable), 8'h0);
    step();
    chk("resume_tick", 8'(bus.enable), 8'h1);
    step(); step(); step();
    chk("pre_expiry", 8'(bus.enable), 8'h0);
    bus.timer_zero = 1;
    step();
    chk("expiry", outs(), 8'b0_11_0_1_1_0_1);
    bus.start = 1;
    step(); step(); step();
    chk("done_ignores_start", outs(), 8'b0_11_0_1_1_0_1);
    bus.start = 0;
    bus.timer_zero = 0;
    bus.load = 1;
    step(); step();
    chk("done_load", outs(), 8'b0_00_0_0_1_0_0);
    bus.load = 0;
    bus.start = 1;
    step(); step();
    chk("rerun", outs(), 8'b0_01_0_1_1_1_0);
    bus.start = 0;
    step();
    bus.clear = 1; bus.stop = 1;
    step(); step();
    chk("prio_clear", outs(), 8'b0_00_0_1_0_0_0);
    bus.clear = 0; bus.stop = 0;
    step();
    chk("clr_once", outs(), 8'b0_00_0_1_1_0_0);
    bus.start = 1;
    changes = 0;
    last = bus.state;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.state !== last) changes++;
      last = bus.state;
    end
    chk("held_start_changes", 8'(changes), 8'h1);
    chk("held_start_state", 8'(bus.state), 8'h1);
    bus.start = 0;
    bus.clear = 1;
    step(); step();
    chk("clear_run", outs(), 8'b0_00_0_1_0_0_0);
    bus.clear = 0;
    bus.timer_zero = 1;
    bus.start = 1;
    step(); step(); step();
    chk("zero_start", outs(), 8'b0_00_0_1_1_0_0);
    bus.start = 0;
    bus.timer_zero = 0;
    step();
    bus.start = 1;
    step(); step();
    chk("run_before_rst", 8'(bus.state), 8'h1);
    bus.start = 0;
    step(); step();
    #2 clrn = 1'b0;
    #1;
    chk("async_reset", outs(), 8'b0_00_0_1_1_0_0);
    #3 clrn = 1'b1;
    step();
    chk("post_reset", outs(), 8'b0_00_0_1_1_0_0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
